// File: rtl/drm_rd_pkg.sv
// rtl/drm_rd_pkg.sv - shared types and helpers for the SDPRAM read streamer
package drm_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } rd_state_e;

  localparam int RD_LATENCY_NO_OREG = 1;
  localparam int RD_LATENCY_OREG    = 2;

  // One slot per in-flight read plus one so a full-rate stream never stalls issue.
  function automatic int buf_depth(input int rd_latency);
    return rd_latency + 1;
  endfunction

endpackage

// File: rtl/drm_rd_skid_fifo.sv
// rtl/drm_rd_skid_fifo.sv - small register FIFO holding {last, data} read beats
module drm_rd_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 9,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] occupancy_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o      = mem_q[rd_ptr_q];
  assign empty_o     = (count_q == '0);
  assign occupancy_o = count_q;

endmodule

// File: rtl/drm_sdpram_rd_streamer.sv
// rtl/drm_sdpram_rd_streamer.sv - issues SDPRAM reads for a command and streams the words out
module drm_sdpram_rd_streamer
  import drm_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam int BUF_DEPTH = buf_depth(RD_LATENCY);
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);
  localparam int CNT_W     = $clog2(2 * BUF_DEPTH + 1);

  rd_state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [ADDR_WIDTH:0]       rem_q, rem_d;
  logic                      cmd_ready_q;
  logic                      done_q, done_d;
  logic [RD_LATENCY-1:0]     vld_sr_q, vld_sr_d;
  logic [RD_LATENCY-1:0]     last_sr_q, last_sr_d;
  logic                      issue;
  logic                      pop;
  logic                      credit;
  logic                      fifo_empty;
  logic [OCC_W-1:0]          occ;
  logic [CNT_W-1:0]          inflight;
  logic [DATA_WIDTH:0]       head;

  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;

  // A word popped this cycle frees its slot in time for a read issued now.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CNT_W'(vld_sr_q[i]);
    credit = (CNT_W'(occ) + inflight) < (CNT_W'(BUF_DEPTH) + CNT_W'(pop));
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = cmd_addr;
            rem_d   = cmd_len;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (credit) begin
          issue  = 1'b1;
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == (ADDR_WIDTH + 1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head[DATA_WIDTH]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    vld_sr_d     = vld_sr_q << 1;
    vld_sr_d[0]  = issue;
    last_sr_d    = last_sr_q << 1;
    last_sr_d[0] = issue && (rem_q == (ADDR_WIDTH + 1)'(1));
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      cmd_ready_q <= 1'b0;
      done_q      <= 1'b0;
      vld_sr_q    <= '0;
      last_sr_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      cmd_ready_q <= (state_d == IDLE);
      done_q      <= done_d;
      vld_sr_q    <= vld_sr_d;
      last_sr_q   <= last_sr_d;
    end
  end

  drm_rd_skid_fifo #(
    .DEPTH(BUF_DEPTH),
    .WIDTH(DATA_WIDTH + 1),
    .CNT_W(OCC_W)
  ) u_buf (
    .clk_i       (rd_clk),
    .rst_n_i     (rd_rst_n),
    .push_i      (vld_sr_q[RD_LATENCY-1]),
    .push_data_i ({last_sr_q[RD_LATENCY-1], ram_rd_data}),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .occupancy_o (occ)
  );

  assign cmd_ready   = cmd_ready_q;
  assign ram_rd_addr = addr_q;
  assign m_data      = head[DATA_WIDTH-1:0];
  assign m_last      = head[DATA_WIDTH];
  assign busy        = (state_q != IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_drm_sdpram_rd_streamer.sv
// tb/tb_drm_sdpram_rd_streamer.sv - scoreboard bench running RD_LATENCY=1 and RD_LATENCY=2 side by side
module tb_drm_sdpram_rd_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       cmd_valid;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_len;
  logic       m_ready;

  logic       cmd_ready [2];
  logic       busy      [2];
  logic       done      [2];
  logic       m_valid   [2];
  logic       m_last    [2];
  logic [7:0] m_data    [2];
  logic [6:0] ram_addr  [2];
  logic [7:0] ram_data  [2];

  logic [7:0] mem [128];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;
  bit rdy_rand = 1'b0;
  int len0_cyc = -100;
  int acc_cyc  = 0;
  logic [8:0] exp0_q[$];
  logic [8:0] exp1_q[$];

  int hs_last_cyc [2];
  int last_beat_cyc [2];
  bit held_v [2];
  logic [8:0] held [2];

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = g + 1;
    logic [7:0] rd_pipe [LAT];

    always @(posedge clk) begin
      rd_pipe[0] <= mem[ram_addr[g]];
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_data[g] = rd_pipe[LAT-1];

    drm_sdpram_rd_streamer #(
      .ADDR_WIDTH(7),
      .DATA_WIDTH(8),
      .RD_LATENCY(LAT)
    ) u_dut (
      .rd_clk      (clk),
      .rd_rst_n    (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready[g]),
      .cmd_addr    (cmd_addr),
      .cmd_len     (cmd_len),
      .ram_rd_addr (ram_addr[g]),
      .ram_rd_data (ram_data[g]),
      .m_valid     (m_valid[g]),
      .m_ready     (m_ready),
      .m_data      (m_data[g]),
      .m_last      (m_last[g]),
      .busy        (busy[g]),
      .done        (done[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, checks done timing and stall stability.
  always @(negedge clk) begin
    logic [8:0] e;
    logic       have;
    logic       exp_done;
    for (int g = 0; g < 2; g++) begin
      if (!mon_en) begin
        held_v[g]      = 1'b0;
        hs_last_cyc[g] = -100;
      end else begin
        exp_done = (hs_last_cyc[g] == cyc - 1) || (len0_cyc == cyc);
        checks++;
        if (done[g] !== exp_done) begin
          fails++;
          $display("FAIL done_l%0d cyc %0d: got %b expected %b", g + 1, cyc, done[g], exp_done);
        end
        if (held_v[g]) begin
          checks++;
          if (m_valid[g] !== 1'b1 || {m_last[g], m_data[g]} !== held[g]) begin
            fails++;
            $display("FAIL stall_hold_l%0d: got v=%b %h expected v=1 %h", g + 1, m_valid[g],
                     {m_last[g], m_data[g]}, held[g]);
          end
        end
        if (m_valid[g] && m_ready) begin
          if (g == 0) begin
            have = exp0_q.size() > 0;
            if (have) e = exp0_q.pop_front();
          end else begin
            have = exp1_q.size() > 0;
            if (have) e = exp1_q.pop_front();
          end
          checks++;
          if (!have) begin
            fails++;
            $display("FAIL extra_beat_l%0d: got %h expected no beat", g + 1, {m_last[g], m_data[g]});
          end else if ({m_last[g], m_data[g]} !== e) begin
            fails++;
            $display("FAIL beat_l%0d: got %h expected %h", g + 1, {m_last[g], m_data[g]}, e);
          end
          last_beat_cyc[g] = cyc;
          if (m_last[g]) hs_last_cyc[g] = cyc;
        end
        held_v[g] = m_valid[g] && !m_ready;
        held[g]   = {m_last[g], m_data[g]};
      end
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk_rst(input string tag);
    for (int g = 0; g < 2; g++)
      chk($sformatf("%s_outs_l%0d", tag, g + 1),
          {12'h0, cmd_ready[g], m_valid[g], m_last[g], busy[g], done[g], m_data[g], ram_addr[g]}, 32'h0);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_cmd(input logic [6:0] a, input int n);
    int t;
    logic [6:0] ad;
    t = 0;
    while (!(cmd_ready[0] && cmd_ready[1]) && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 2000) begin
      chk("cmd_ready_timeout", 32'(t), 32'(0));
      return;
    end
    for (int i = 0; i < n; i++) begin
      ad = a + 7'(i);
      exp0_q.push_back({i == n - 1, mem[ad]});
      exp1_q.push_back({i == n - 1, mem[ad]});
    end
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = 8'(n);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    acc_cyc   = cyc;
    if (n == 0) len0_cyc = cyc;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(exp0_q.size() == 0 && exp1_q.size() == 0 && !busy[0] && !busy[1]) && t < 5000);
    if (t >= 5000) chk({tag, "_idle_timeout"}, 32'(exp0_q.size() + exp1_q.size()), 32'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat [2];
    bit seen [2];
    int nb;
    int t;
    logic [6:0] ra;
    int rn;

    for (int a = 0; a < 128; a++) mem[a] = 8'hFF - 8'(a);
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_rst("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst_l1", 32'(cmd_ready[0]), 32'd1);
    chk("ready_after_rst_l2", 32'(cmd_ready[1]), 32'd1);

    // Full sweep at full rate: latency to first beat and no bubbles.
    rdy_rand = 1'b0;
    send_cmd(7'h00, 128);
    seen[0] = 1'b0;
    seen[1] = 1'b0;
    lat[0]  = -1;
    lat[1]  = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++)
        if (!seen[g] && m_valid[g]) begin
          seen[g] = 1'b1;
          lat[g]  = k;
        end
    end
    chk("first_beat_lat_l1", 32'(lat[0]), 32'd2);
    chk("first_beat_lat_l2", 32'(lat[1]), 32'd3);
    wait_idle("sweep");
    chk("last_beat_cyc_l1", 32'(last_beat_cyc[0] - acc_cyc), 32'd129);
    chk("last_beat_cyc_l2", 32'(last_beat_cyc[1] - acc_cyc), 32'd130);

    send_cmd(7'h7E, 4);
    wait_idle("wrap");

    rdy_rand = 1'b1;
    send_cmd(7'h00, 128);
    wait_idle("rand_ready");

    for (int r = 0; r < 6; r++) begin
      ra = 7'($urandom_range(0, 127));
      rn = $urandom_range(1, 128);
      rdy_rand = r[0];
      send_cmd(ra, rn);
      wait_idle("rand_cmd");
    end

    rdy_rand = 1'b0;
    send_cmd(7'h05, 0);
    repeat (4) @(posedge clk);
    #1;
    wait_idle("len0");

    // Commands offered while busy must be ignored.
    send_cmd(7'h10, 20);
    cmd_valid = 1'b1;
    cmd_addr  = 7'h40;
    cmd_len   = 8'd3;
    for (int i = 0; i < 5; i++) begin
      chk("busy_reject_ready_l1", 32'(cmd_ready[0]), 32'd0);
      chk("busy_reject_ready_l2", 32'(cmd_ready[1]), 32'd0);
      chk("busy_flag_l1", 32'(busy[0]), 32'd1);
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    wait_idle("busy_reject");

    // Reset in the middle of a long command.
    send_cmd(7'h00, 128);
    nb = 0;
    t  = 0;
    while (nb < 10 && t < 500) begin
      @(negedge clk);
      t++;
      if (m_valid[0] && m_ready) nb++;
    end
    chk("midrst_beats", 32'(nb), 32'd10);
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    chk_rst("midrst");
    rst_n = 1'b1;
    exp0_q.delete();
    exp1_q.delete();
    len0_cyc = -100;
    mon_en   = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send_cmd(7'h00, 2);
    wait_idle("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
